// File: rtl/tt_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding
// and the upper bound on the per-vector settle time.
package tt_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/tt_sweeper_settle_timer.sv
// 4-bit loadable down-counter that times how long each vector is held.
// Ports: clk, rst (sync, active-high), load/value (reload), expire (count==1).
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] value,
    output logic       expire
);

    logic [3:0] count;

    // Stops at zero so an idle timer never wraps back into expire.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 4'd1;
        end
    end

    assign expire = (count == 4'd1);

endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive stimulus/response sweeper for a small combinational block:
// drives every input vector, samples y after a settle time, builds the
// truth table and compares it with a latched golden word.
// Ports: clk, rst, start, expected[TT_W] in; vec[N_IN], busy, done out;
//        y in; tt[TT_W], pass, err_count[N_IN+1], first_err[N_IN],
//        first_err_valid out.
module tt_sweeper
    import tt_sweeper_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1,
    parameter int TT_W   = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TT_W-1:0]   expected,
    output logic [N_IN-1:0]   vec,
    input  logic              y,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   tt,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_err,
    output logic              first_err_valid
);

    if (SETTLE < 1 || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("tt_sweeper: SETTLE must be within 1..15");
    end

    if (TT_W != 2 ** N_IN) begin : g_bad_ttw
        $error("tt_sweeper: TT_W is derived and must equal 2**N_IN");
    end

    localparam logic [N_IN-1:0] VEC_LAST = '1;

    function automatic logic [N_IN:0] popcount(input logic [TT_W-1:0] v);
        logic [N_IN:0] n;
        n = '0;
        for (int i = 0; i < TT_W; i++) begin
            n = n + {{N_IN{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Scan from the top so the last hit is the lowest set bit.
    function automatic logic [N_IN-1:0] lowest_set(input logic [TT_W-1:0] v);
        logic [N_IN-1:0] idx;
        idx = '0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = N_IN'(i);
            end
        end
        return idx;
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic              expire;
    logic              last;
    logic              accept;
    logic              capture;
    logic              finish;
    logic              load;
    logic [TT_W-1:0]   exp_q;
    logic [TT_W-1:0]   tt_nxt;
    logic [TT_W-1:0]   diff;

    assign last = (vec == VEC_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)  state_nxt = HOLD;
            HOLD:    if (expire) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs decoded from the state
    always_comb begin
        accept  = (state == IDLE) && start;
        capture = (state == SAMPLE);
        finish  = capture && last;
        load    = accept || (capture && !last);
        busy    = (state != IDLE);
    end

    settle_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .value  (4'(SETTLE)),
        .expire (expire)
    );

    always_comb begin
        tt_nxt      = tt;
        tt_nxt[vec] = y;
        diff        = tt_nxt ^ exp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec             <= '0;
            done            <= 1'b0;
            tt              <= '0;
            exp_q           <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                exp_q           <= expected;
                vec             <= '0;
                tt              <= '0;
                pass            <= 1'b0;
                err_count       <= '0;
                first_err       <= '0;
                first_err_valid <= 1'b0;
            end
            if (capture) begin
                tt <= tt_nxt;
                if (finish) begin
                    done            <= 1'b1;
                    pass            <= (diff == '0);
                    err_count       <= popcount(diff);
                    first_err       <= lowest_set(diff);
                    first_err_valid <= (diff != '0);
                end else begin
                    vec <= vec + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_sweeper.sv
// Self-checking bench for tt_sweeper: truth-table driven DUT models,
// random tables checked against a set-level reference model.
module tb_tt_sweeper;

    logic       clk = 1'b0;
    logic       rst;

    logic       start1;
    logic [7:0] expected1;
    logic [2:0] vec1;
    logic       y1;
    logic       busy1;
    logic       done1;
    logic [7:0] tt1;
    logic       pass1;
    logic [3:0] err_count1;
    logic [2:0] first_err1;
    logic       first_err_valid1;

    logic       start3;
    logic [7:0] expected3;
    logic [2:0] vec3;
    logic       y3;
    logic       busy3;
    logic       done3;
    logic [7:0] tt3;
    logic       pass3;
    logic [3:0] err_count3;
    logic [2:0] first_err3;
    logic       first_err_valid3;

    logic [7:0] tbl1;
    logic [7:0] tbl3;
    logic [2:0] hist [4];
    int         dly;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tt_sweeper u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .start           (start1),
        .expected        (expected1),
        .vec             (vec1),
        .y               (y1),
        .busy            (busy1),
        .done            (done1),
        .tt              (tt1),
        .pass            (pass1),
        .err_count       (err_count1),
        .first_err       (first_err1),
        .first_err_valid (first_err_valid1)
    );

    tt_sweeper #(.SETTLE(3)) u_dut3 (
        .clk             (clk),
        .rst             (rst),
        .start           (start3),
        .expected        (expected3),
        .vec             (vec3),
        .y               (y3),
        .busy            (busy3),
        .done            (done3),
        .tt              (tt3),
        .pass            (pass3),
        .err_count       (err_count3),
        .first_err       (first_err3),
        .first_err_valid (first_err_valid3)
    );

    // Combinational block under test: a lookup table indexed by vec.
    assign y1 = tbl1[vec1];

    // Slow block: y follows vec only dly clock edges later.
    always @(posedge clk) begin
        hist[3] <= hist[2];
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= vec3;
    end
    assign y3 = (dly == 4) ? tbl3[hist[3]] : tbl3[hist[2]];

    function automatic logic [7:0] table_of(input int kind);
        logic [7:0] t;
        for (int k = 0; k < 8; k++) begin
            logic a, b, c;
            a = ((k >> 2) & 1) != 0;
            b = ((k >> 1) & 1) != 0;
            c = (k & 1) != 0;
            if (kind == 0) t[k] = a ^ b ^ c;
            else           t[k] = a | (b & c);
        end
        return t;
    endfunction

    function automatic int ref_errs(input logic [7:0] got, input logic [7:0] want);
        int n = 0;
        for (int k = 0; k < 8; k++) if (got[k] != want[k]) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [7:0] got, input logic [7:0] want);
        for (int k = 0; k < 8; k++) if (got[k] != want[k]) return k;
        return 0;
    endfunction

    // Pulse start on DUT1 and wait for done; dcyc is edges after E0.
    task automatic sweep1(input logic [7:0] e, output int dcyc, output int bcnt);
        @(negedge clk);
        expected1 = e;
        start1    = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        dcyc   = -1;
        bcnt   = 0;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy1) bcnt++;
            if (done1) begin
                dcyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({vec1, busy1, done1, tt1, pass1, err_count1, first_err1, first_err_valid1} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got vec=%0d busy=%b done=%b tt=%h pass=%b ec=%0d fe=%0d fev=%b, want all 0",
                     vec1, busy1, done1, tt1, pass1, err_count1, first_err1, first_err_valid1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_parity_pass;
        int d, b;
        tbl1 = table_of(0);
        sweep1(8'h96, d, b);
        tests++;
        if (d !== 16) begin
            fails++;
            $display("FAIL parity_done_cycle: got %0d, want 16", d);
        end
        tests++;
        if (b !== 16) begin
            fails++;
            $display("FAIL parity_busy_cycles: got %0d, want 16", b);
        end
        tests++;
        if ({tt1, pass1, err_count1, first_err_valid1} !== {8'h96, 1'b1, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL parity_results: got tt=%h pass=%b ec=%0d fev=%b, want 96 1 0 0",
                     tt1, pass1, err_count1, first_err_valid1);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({done1, vec1} !== {1'b0, 3'd7}) begin
            fails++;
            $display("FAIL done_one_cycle: got done=%b vec=%0d, want 0 7", done1, vec1);
        end
    endtask

    task automatic test_mismatch;
        int d, b;
        logic [7:0] t;
        tbl1 = table_of(0);
        sweep1(8'h97, d, b);
        tests++;
        if ({tt1, pass1, err_count1, first_err1, first_err_valid1} !== {8'h96, 1'b0, 4'd1, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL single_err: got tt=%h pass=%b ec=%0d fe=%0d fev=%b, want 96 0 1 0 1",
                     tt1, pass1, err_count1, first_err1, first_err_valid1);
        end
        t    = table_of(1);
        tbl1 = t;
        sweep1(8'h96, d, b);
        tests++;
        if ({tt1, pass1, err_count1, first_err1, first_err_valid1} !==
            {t, 1'b0, 4'(ref_errs(t, 8'h96)), 3'(ref_first(t, 8'h96)), 1'b1}) begin
            fails++;
            $display("FAIL or_and_errs: got tt=%h ec=%0d fe=%0d, want %h %0d %0d",
                     tt1, err_count1, first_err1, t, ref_errs(t, 8'h96), ref_first(t, 8'h96));
        end
    endtask

    task automatic test_random;
        int d, b;
        logic [7:0] t, e;
        for (int i = 0; i < 8; i++) begin
            t = 8'($urandom);
            e = (i == 0) ? t : 8'($urandom);
            tbl1 = t;
            sweep1(e, d, b);
            tests++;
            if (d !== 16 ||
                {tt1, pass1, err_count1, first_err1, first_err_valid1} !==
                {t, t == e, 4'(ref_errs(t, e)), 3'(ref_first(t, e)), t != e}) begin
                fails++;
                $display("FAIL random_%0d: got d=%0d tt=%h pass=%b ec=%0d fe=%0d fev=%b, want tt=%h exp=%h ec=%0d fe=%0d",
                         i, d, tt1, pass1, err_count1, first_err1, first_err_valid1,
                         t, e, ref_errs(t, e), ref_first(t, e));
            end
        end
    endtask

    task automatic test_back_to_back;
        int dones[$];
        int lows;
        int cleared_bad;
        tbl1 = table_of(0);
        lows = 0;
        cleared_bad = 0;
        @(negedge clk);
        expected1 = 8'h96;
        start1    = 1'b1;
        for (int c = 0; c < 52; c++) begin
            @(posedge clk);
            #1;
            if (!busy1) lows++;
            if (done1) dones.push_back(c);
            if (dones.size() > 0 && c == dones[$] + 1 && tt1 !== 8'h00) cleared_bad++;
        end
        @(negedge clk);
        start1 = 1'b0;
        tests++;
        if (dones.size() != 3 || dones[0] != 16 || dones[1] != 33 || dones[2] != 50) begin
            fails++;
            $display("FAIL b2b_done_period: got %0d pulses, want at 16 33 50", dones.size());
        end
        tests++;
        if (lows !== 3) begin
            fails++;
            $display("FAIL b2b_busy_low: got %0d idle cycles, want 3", lows);
        end
        tests++;
        if (cleared_bad !== 0) begin
            fails++;
            $display("FAIL b2b_results_cleared: got %0d uncleared starts, want 0", cleared_bad);
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        int seen, d, b;
        tbl1 = table_of(0);
        @(negedge clk);
        expected1 = 8'h96;
        start1    = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({vec1, busy1, done1, tt1, pass1, err_count1, first_err1, first_err_valid1} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got vec=%0d busy=%b done=%b tt=%h, want all 0",
                     vec1, busy1, done1, tt1);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL mid_reset_quiet: got %0d active cycles, want 0", seen);
        end
        sweep1(8'h96, d, b);
        tests++;
        if (d !== 16 || tt1 !== 8'h96 || pass1 !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_sweep: got d=%0d tt=%h pass=%b, want 16 96 1", d, tt1, pass1);
        end
    endtask

    task automatic test_settle;
        int d;
        logic [7:0] t, want;
        t    = table_of(0);
        tbl3 = t;
        for (int pass_no = 0; pass_no < 2; pass_no++) begin
            dly = (pass_no == 0) ? 3 : 4;
            repeat (6) @(posedge clk);
            @(negedge clk);
            expected3 = 8'h96;
            start3    = 1'b1;
            @(posedge clk);
            #1;
            start3 = 1'b0;
            d = -1;
            for (int c = 1; c <= 60; c++) begin
                @(posedge clk);
                #1;
                if (done3) begin
                    d = c;
                    break;
                end
            end
            // One edge too slow: each slot sees the previous vector's
            // response, and slot 0 sees the parked vector 7.
            for (int k = 0; k < 8; k++) want[k] = (dly == 3) ? t[k] : t[(k + 7) % 8];
            tests++;
            if (d !== 32 || tt3 !== want || pass3 !== (want == 8'h96)) begin
                fails++;
                $display("FAIL settle3_dly%0d: got d=%0d tt=%h pass=%b, want 32 %h %b",
                         dly, d, tt3, pass3, want, want == 8'h96);
            end
        end
    endtask

    task automatic test_ignore_inputs;
        int d;
        tbl1 = table_of(0);
        @(negedge clk);
        expected1 = 8'h96;
        start1    = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expected1 = 8'h00;
        start1    = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        d = -1;
        for (int c = 5; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                d = c;
                break;
            end
        end
        tests++;
        if (d !== 16 || pass1 !== 1'b1 || err_count1 !== 4'd0) begin
            fails++;
            $display("FAIL ignore_mid_sweep: got d=%0d pass=%b ec=%0d, want 16 1 0", d, pass1, err_count1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start1    = 1'b0;
        start3    = 1'b0;
        expected1 = '0;
        expected3 = '0;
        tbl1      = '0;
        tbl3      = '0;
        dly       = 3;
        repeat (2) @(posedge clk);
        test_reset;
        test_parity_pass;
        test_mismatch;
        test_random;
        test_back_to_back;
        test_reset_mid;
        test_settle;
        test_ignore_inputs;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
